int_div_share_arb: RTL and testbench

//  Shares one iterative integer divider (DIV/DIVU/REM/REMU, 3-bit op) between NB_CORES requesters.

---
 rtl/int_div_share_arb.sv | 108 ++++++++++
 tb/tb_int_div_share_arb.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_div_share_arb.sv
// Round-robin arbiter that shares one iterative integer divider between NB_CORES requesters.
// One operation in flight at a time; issue and return paths are purely combinational.
module int_div_share_arb #(
  parameter int unsigned NB_CORES  = 4,
  parameter int unsigned TAG_WIDTH = 5
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NB_CORES-1:0]                 req_i,
  input  logic [NB_CORES-1:0][2:0]            op_i,
  input  logic [NB_CORES-1:0][31:0]           opa_i,
  input  logic [NB_CORES-1:0][31:0]           opb_i,
  input  logic [NB_CORES-1:0][TAG_WIDTH-1:0]  tag_i,
  output logic [NB_CORES-1:0]                 gnt_o,
  output logic [NB_CORES-1:0]                 rvalid_o,
  output logic [31:0]                         rdata_o,
  output logic [TAG_WIDTH-1:0]                rtag_o,
  output logic                                div_en_o,
  output logic [2:0]                          div_op_o,
  output logic [31:0]                         div_opa_o,
  output logic [31:0]                         div_opb_o,
  output logic [TAG_WIDTH-1:0]                div_tag_o,
  input  logic                                div_ready_i,
  input  logic                                div_valid_i,
  input  logic [31:0]                         div_res_i,
  input  logic [TAG_WIDTH-1:0]                div_tag_i,
  output logic                                busy_o
);

  localparam int unsigned ID_WIDTH = $clog2(NB_CORES);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0] owner_q, owner_d;
  logic [ID_WIDTH-1:0] win_idx;
  logic                win_found;

  // Pick the first requester at or after rr_ptr, wrapping modulo NB_CORES.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    for (int unsigned i = 0; i < NB_CORES; i++) begin
      if (!win_found && req_i[(32'(rr_ptr_q) + i) % NB_CORES]) begin
        win_found = 1'b1;
        win_idx   = ID_WIDTH'((32'(rr_ptr_q) + i) % NB_CORES);
      end
    end
  end

  // Next-state logic plus combinational issue/return routing.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    gnt_o     = '0;
    rvalid_o  = '0;
    rdata_o   = '0;
    rtag_o    = '0;
    div_en_o  = 1'b0;
    div_op_o  = '0;
    div_opa_o = '0;
    div_opb_o = '0;
    div_tag_o = '0;
    busy_o    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (win_found && div_ready_i) begin
          gnt_o[win_idx] = 1'b1;
          div_en_o       = 1'b1;
          div_op_o       = op_i[win_idx];
          div_opa_o      = opa_i[win_idx];
          div_opb_o      = opb_i[win_idx];
          div_tag_o      = tag_i[win_idx];
          owner_d        = win_idx;
          state_d        = StBusy;
        end
      end
      StBusy: begin
        busy_o = 1'b1;
        if (div_valid_i) begin
          rvalid_o[owner_q] = 1'b1;
          rdata_o           = div_res_i;
          rtag_o            = div_tag_i;
          // Priority moves to the core just after the one that was served.
          rr_ptr_d = (owner_q == ID_WIDTH'(NB_CORES - 1)) ? '0 : owner_q + 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset drops any in-flight operation.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
    end
  end

endmodule

// File: tb/tb_int_div_share_arb.sv
// Self-checking bench: behavioural divider model plus a result scoreboard.
module tb_int_div_share_arb;

  localparam int unsigned NB  = 4;
  localparam int unsigned TW  = 5;
  localparam int          LAT = 4;

  localparam logic [2:0] OpDiv  = 3'd4;
  localparam logic [2:0] OpDivu = 3'd5;
  localparam logic [2:0] OpRem  = 3'd6;
  localparam logic [2:0] OpRemu = 3'd7;

  logic                   clk_i = 1'b0;
  logic                   rst_ni = 1'b0;
  logic [NB-1:0]          req_i = '0;
  logic [NB-1:0][2:0]     op_i = '0;
  logic [NB-1:0][31:0]    opa_i = '0;
  logic [NB-1:0][31:0]    opb_i = '0;
  logic [NB-1:0][TW-1:0]  tag_i = '0;
  logic [NB-1:0]          gnt_o, rvalid_o;
  logic [31:0]            rdata_o;
  logic [TW-1:0]          rtag_o;
  logic                   div_en_o;
  logic [2:0]             div_op_o;
  logic [31:0]            div_opa_o, div_opb_o;
  logic [TW-1:0]          div_tag_o;
  logic                   div_ready_i, div_valid_i;
  logic [31:0]            div_res_i;
  logic [TW-1:0]          div_tag_i;
  logic                   busy_o;

  // Divider model state
  logic          ready_en = 1'b1;
  logic          spur = 1'b0;
  logic          m_busy, m_valid;
  int            m_cnt;
  logic [2:0]    m_op;
  logic [31:0]   m_a, m_b, m_res;
  logic [TW-1:0] m_tag, m_rtag;

  typedef struct {
    int unsigned core;
    logic [31:0] res;
    logic [TW-1:0] tag;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  int_div_share_arb #(.NB_CORES(NB), .TAG_WIDTH(TW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .op_i(op_i), .opa_i(opa_i),
    .opb_i(opb_i), .tag_i(tag_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .rtag_o(rtag_o), .div_en_o(div_en_o), .div_op_o(div_op_o), .div_opa_o(div_opa_o),
    .div_opb_o(div_opb_o), .div_tag_o(div_tag_o), .div_ready_i(div_ready_i),
    .div_valid_i(div_valid_i), .div_res_i(div_res_i), .div_tag_i(div_tag_i), .busy_o(busy_o)
  );

  function automatic logic [31:0] div_fn(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OpDiv:   return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'($signed(a) / $signed(b)));
      OpDivu:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OpRem:   return (b == 0) ? a : (ovf ? 32'd0 : 32'($signed(a) % $signed(b)));
      OpRemu:  return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  assign div_ready_i = ready_en && !m_busy;
  assign div_valid_i = m_valid | spur;
  assign div_res_i   = m_res;
  assign div_tag_i   = m_rtag;

  // Fixed-latency divider model sharing the DUT reset.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_cnt   <= 0;
      m_res   <= '0;
      m_rtag  <= '0;
    end else begin
      m_valid <= 1'b0;
      if (div_en_o && div_ready_i) begin
        m_busy <= 1'b1;
        m_cnt  <= LAT;
        m_op   <= div_op_o;
        m_a    <= div_opa_o;
        m_b    <= div_opb_o;
        m_tag  <= div_tag_o;
      end else if (m_busy) begin
        if (m_cnt == 1) begin
          m_valid <= 1'b1;
          m_res   <= div_fn(m_op, m_a, m_b);
          m_rtag  <= m_tag;
          m_busy  <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  // Scoreboard: every result pulse must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (rst_ni && (rvalid_o != '0)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rvalid: rvalid_o=%b rdata_o=%h with nothing outstanding",
                 rvalid_o, rdata_o);
      end else begin
        exp_t e;
        logic [NB-1:0] oh;
        e = sb.pop_front();
        oh = '0;
        oh[e.core] = 1'b1;
        if (rvalid_o !== oh || rdata_o !== e.res || rtag_o !== e.tag) begin
          errors++;
          $display("FAIL result: got rvalid=%b rdata=%h rtag=%0d, want rvalid=%b rdata=%h rtag=%0d",
                   rvalid_o, rdata_o, rtag_o, oh, e.res, e.tag);
        end
      end
    end
  end

  // Starts at posedge+1; returns at the negedge of the grant cycle.
  task automatic wait_gnt(input int c, input string name);
    int n;
    logic [NB-1:0] oh;
    oh = '0;
    oh[c] = 1'b1;
    n = 0;
    @(negedge clk_i);
    while (gnt_o == '0 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (gnt_o !== oh) begin
      errors++;
      $display("FAIL %s_gnt: gnt_o=%b want %b", name, gnt_o, oh);
    end
  endtask

  task automatic drive(input int c, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [TW-1:0] t);
    op_i[c]  = op;
    opa_i[c] = a;
    opb_i[c] = b;
    tag_i[c] = t;
    req_i[c] = 1'b1;
  endtask

  // Single-core issue: check grant and pass-through, then drop the request.
  task automatic issue(input int c, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [TW-1:0] t, input logic [31:0] exp,
                       input bit expect_result, input string name);
    drive(c, op, a, b, t);
    if (expect_result) sb.push_back('{c, exp, t});
    wait_gnt(c, name);
    checks++;
    if (div_en_o !== 1'b1 || div_op_o !== op || div_opa_o !== a || div_opb_o !== b ||
        div_tag_o !== t) begin
      errors++;
      $display("FAIL %s_issue: en=%b op=%0d a=%h b=%h tag=%0d want en=1 op=%0d a=%h b=%h tag=%0d",
               name, div_en_o, div_op_o, div_opa_o, div_opb_o, div_tag_o, op, a, b, t);
    end
    @(posedge clk_i);
    #1;
    req_i[c] = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d results outstanding, want 0", name, sb.size());
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    checks++;
    if (gnt_o !== '0 || rvalid_o !== '0 || div_en_o !== 1'b0 || busy_o !== 1'b0 ||
        rdata_o !== '0 || rtag_o !== '0 || div_op_o !== '0 || div_opa_o !== '0 ||
        div_opb_o !== '0 || div_tag_o !== '0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b rvalid=%b en=%b busy=%b rdata=%h, want all 0",
               gnt_o, rvalid_o, div_en_o, busy_o, rdata_o);
    end
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    issue(0, OpDivu, 32'd100, 32'd7, 5'd3, 32'd14, 1'b1, "basic");
    @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: busy_o=%b want 1", busy_o);
    end
    wait_drain("basic");
  endtask

  task automatic test_round_robin();
    logic [31:0] a[4] = '{32'd100, 32'd200, 32'd50, 32'hFFFF_FFEC};
    logic [31:0] b[4] = '{32'd7, 32'd8, 32'd7, 32'd3};
    logic [2:0]  o[4] = '{OpDivu, OpDivu, OpRemu, OpDiv};
    logic [31:0] r[4] = '{32'd14, 32'd25, 32'd1, 32'hFFFF_FFFA};
    // Wrap the pointer back to core0 first.
    issue(3, OpDivu, 32'd21, 32'd7, 5'd1, 32'd3, 1'b1, "rr_setup");
    wait_drain("rr_setup");
    for (int k = 0; k < 4; k++) drive(k, o[k], a[k], b[k], TW'(10 + k));
    for (int g = 0; g < 5; g++) sb.push_back('{g % 4, r[g % 4], TW'(10 + g % 4)});
    for (int g = 0; g < 5; g++) begin
      wait_gnt(g % 4, "rr");
      @(posedge clk_i);
      #1;
      if (g == 4) req_i = '0;
    end
    wait_drain("rr");
  endtask

  task automatic test_busy_block();
    issue(2, OpRem, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, 1'b1, "busy_core2");
    drive(1, OpDivu, 32'd9, 32'd3, 5'd8);
    sb.push_back('{1, 32'd3, 5'd8});
    for (int i = 0; i < LAT - 1; i++) begin
      @(negedge clk_i);
      checks++;
      if (gnt_o !== '0 || div_en_o !== 1'b0 || busy_o !== 1'b1) begin
        errors++;
        $display("FAIL busy_no_gnt: gnt=%b en=%b busy=%b want 0000/0/1", gnt_o, div_en_o, busy_o);
      end
    end
    @(posedge clk_i);
    #1;
    wait_gnt(1, "busy_core1");
    @(posedge clk_i);
    #1;
    req_i[1] = 1'b0;
    wait_drain("busy");
  endtask

  task automatic test_div_zero();
    issue(1, OpDiv, 32'd1234, 32'd0, 5'd4, 32'hFFFF_FFFF, 1'b1, "divzero");
    wait_drain("divzero");
    for (int k = 0; k < 4; k++) drive(k, OpDivu, 32'd77, 32'd11, 5'd9);
    sb.push_back('{2, 32'd7, 5'd9});
    wait_gnt(2, "divzero_rrptr");
    @(posedge clk_i);
    #1;
    req_i = '0;
    wait_drain("divzero_rrptr");
  endtask

  task automatic test_mid_reset();
    issue(3, OpDivu, 32'd50, 32'd5, 5'd2, 32'd10, 1'b0, "midrst");
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      checks++;
      if (busy_o !== 1'b0 || rvalid_o !== '0) begin
        errors++;
        $display("FAIL midrst_in_reset: busy=%b rvalid=%b want 0/0000", busy_o, rvalid_o);
      end
    end
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    repeat (LAT + 2) begin
      @(negedge clk_i);
      checks++;
      if (busy_o !== 1'b0 || rvalid_o !== '0) begin
        errors++;
        $display("FAIL midrst_dropped: busy=%b rvalid=%b want 0/0000", busy_o, rvalid_o);
      end
    end
    @(posedge clk_i);
    #1;
    for (int k = 0; k < 4; k++) drive(k, OpDivu, 32'd10, 32'd3, 5'd5);
    sb.push_back('{0, 32'd3, 5'd5});
    wait_gnt(0, "midrst_rrptr");
    @(posedge clk_i);
    #1;
    req_i = '0;
    wait_drain("midrst");
  endtask

  task automatic test_ready_stall();
    issue(3, OpDivu, 32'd8, 32'd2, 5'd6, 32'd4, 1'b1, "stall_setup");
    wait_drain("stall_setup");
    ready_en = 1'b0;
    drive(0, OpRemu, 32'd17, 32'd5, 5'd11);
    drive(1, OpDivu, 32'd40, 32'd4, 5'd12);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checks++;
      if (gnt_o !== '0 || div_en_o !== 1'b0) begin
        errors++;
        $display("FAIL stall_no_gnt: gnt=%b en=%b want 0000/0", gnt_o, div_en_o);
      end
      @(posedge clk_i);
      #1;
    end
    ready_en = 1'b1;
    sb.push_back('{0, 32'd2, 5'd11});
    @(negedge clk_i);
    checks++;
    if (gnt_o !== 4'b0001) begin
      errors++;
      $display("FAIL stall_release_gnt: gnt=%b want 0001", gnt_o);
    end
    @(posedge clk_i);
    #1;
    req_i = '0;
    wait_drain("stall");
  endtask

  task automatic test_spurious();
    spur = 1'b1;
    @(negedge clk_i);
    checks++;
    if (rvalid_o !== '0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL spurious: rvalid=%b busy=%b want 0000/0", rvalid_o, busy_o);
    end
    @(posedge clk_i);
    #1;
    spur = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_busy_block();
    test_div_zero();
    test_mid_reset();
    test_ready_stall();
    test_spurious();
    repeat (3) @(posedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
